// File: rtl/wide_add_sched.sv
// Round-robin scheduler that shares one 8-bit adder (no carry-in) between two
// requesters. Each wide addition runs LSB byte first; an incoming carry costs one extra +1 pass.

module Ripple_Add (
  output logic [7:0] S,
  output logic       Cout,
  input  logic [7:0] A,
  input  logic [7:0] B
);

  logic [8:0] w_c;

  always_comb begin
    w_c    = '0;
    S      = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      S[k]     = A[k] ^ B[k] ^ w_c[k];
      w_c[k+1] = (A[k] & B[k]) | (w_c[k] & (A[k] ^ B[k]));
    end
    Cout = w_c[8];
  end

endmodule

module wide_add_sched #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [8*NBYTES-1:0]   a0,
  input  logic [8*NBYTES-1:0]   b0,
  input  logic [8*NBYTES-1:0]   a1,
  input  logic [8*NBYTES-1:0]   b1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  busy,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_id,
  output logic [8*NBYTES-1:0]   res_sum,
  output logic                  res_cout
);

  localparam int unsigned W  = 8 * NBYTES;
  localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_INC,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_opa;
  logic [W-1:0]    r_opb;
  logic [W-1:0]    r_acc;
  logic [IW-1:0]   r_i;
  logic            r_cy;
  logic            r_c1;
  logic [7:0]      r_tmp;
  logic            r_ptr;
  logic            r_gnt0;
  logic            r_gnt1;
  logic            r_busy;
  logic            r_valid;
  logic            r_id;

  logic [7:0]      w_add_a;
  logic [7:0]      w_add_b;
  logic [7:0]      w_sum;
  logic            w_cout;
  logic            w_last;
  logic            w_win;

  Ripple_Add u_add (
    .S    (w_sum),
    .Cout (w_cout),
    .A    (w_add_a),
    .B    (w_add_b)
  );

  // Adder operands only matter in ADD/INC; zero elsewhere keeps the mux simple.
  always_comb begin
    w_add_a = '0;
    w_add_b = '0;
    case (r_state)
      S_ADD: begin
        for (int unsigned b = 0; b < NBYTES; b++) begin
          if (r_i == IW'(b)) begin
            w_add_a = r_opa[8*b +: 8];
            w_add_b = r_opb[8*b +: 8];
          end
        end
      end
      S_INC: begin
        w_add_a = r_tmp;
        w_add_b = 8'd1;
      end
      default: ;
    endcase
  end

  assign w_last = (r_i == IW'(NBYTES - 1));
  // With both ports asking, ptr picks; otherwise the lone requester wins.
  assign w_win  = (req0 & req1) ? r_ptr : req1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_acc   <= '0;
      r_i     <= '0;
      r_cy    <= 1'b0;
      r_c1    <= 1'b0;
      r_tmp   <= '0;
      r_ptr   <= 1'b0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_id    <= 1'b0;
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req0 | req1) begin
            r_opa   <= w_win ? a1 : a0;
            r_opb   <= w_win ? b1 : b0;
            r_id    <= w_win;
            r_gnt0  <= ~w_win;
            r_gnt1  <= w_win;
            r_i     <= '0;
            r_cy    <= 1'b0;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_tmp <= w_sum;
          r_c1  <= w_cout;
          if (r_cy) begin
            r_state <= S_INC;
          end else begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
              if (r_i == IW'(b)) r_acc[8*b +: 8] <= w_sum;
            end
            r_cy <= w_cout;
            if (w_last) begin
              r_valid <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_i <= r_i + IW'(1);
            end
          end
        end
        S_INC: begin
          for (int unsigned b = 0; b < NBYTES; b++) begin
            if (r_i == IW'(b)) r_acc[8*b +: 8] <= w_sum;
          end
          // tmp+1 only carries when tmp was 0xFF, which excludes c1 = 1.
          r_cy <= r_c1 | w_cout;
          if (w_last) begin
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_i     <= r_i + IW'(1);
            r_state <= S_ADD;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_ptr   <= ~r_id;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign busy      = r_busy;
  assign res_valid = r_valid;
  assign res_id    = r_id;
  assign res_sum   = r_acc;
  assign res_cout  = r_cy;

endmodule

// File: tb/tb_wide_add_sched.sv
// Directed bench for wide_add_sched (NBYTES = 4): sums, compute latency,
// arbitration order, backpressure and asynchronous reset mid-operation.

module tb_wide_add_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        gnt0, gnt1, busy, res_valid, res_id, res_cout;
  logic        res_ready = 1'b0;
  logic [31:0] res_sum;

  int n_tests = 0;
  int n_fail  = 0;

  wide_add_sched #(.NBYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .res_id(res_id), .res_sum(res_sum), .res_cout(res_cout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one request starting at a negedge; returns observed values, stops in DONE.
  task automatic run_op(input bit port, input logic [31:0] a, input logic [31:0] b,
                        output int gdelay, output int cycles, output int extra_gnt,
                        output bit ok, output logic [31:0] sum, output logic cout,
                        output logic id);
    ok = 1'b1; gdelay = 0; cycles = 0; extra_gnt = 0;
    sum = '0; cout = 1'b0; id = 1'b0;
    if (port) begin a1 = a; b1 = b; req1 = 1'b1; end
    else      begin a0 = a; b0 = b; req0 = 1'b1; end
    do begin
      @(negedge clk);
      gdelay++;
    end while (!(port ? gnt1 : gnt0) && gdelay < 20);
    req0 = 1'b0; req1 = 1'b0;
    if (!(port ? gnt1 : gnt0)) begin ok = 1'b0; return; end
    cycles = 1;
    while (1) begin
      @(negedge clk);
      if (res_valid) break;
      if (gnt0 | gnt1) extra_gnt++;
      cycles++;
      if (cycles > 40) begin ok = 1'b0; return; end
    end
    sum = res_sum; cout = res_cout; id = res_id;
  endtask

  task automatic accept(output logic v_after, output logic busy_after);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    v_after = res_valid;
    busy_after = busy;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt0: got %b want 0", gnt0); end
    n_tests++; if (gnt1 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt1: got %b want 0", gnt1); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", res_valid); end
    n_tests++; if (res_id !== 1'b0) begin n_fail++; $display("FAIL reset_id: got %b want 0", res_id); end
    n_tests++; if (res_cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b want 0", res_cout); end
    n_tests++; if (res_sum !== 32'h0) begin n_fail++; $display("FAIL reset_sum: got %h want 0", res_sum); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int gd, cyc, xg; bit ok; logic [31:0] s; logic c, id, va, ba;
    run_op(1'b0, 32'h5, 32'h3, gd, cyc, xg, ok, s, c, id);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b want 1", ok); end
    n_tests++; if (gd != 1) begin n_fail++; $display("FAIL basic_gnt_delay: got %0d want 1", gd); end
    n_tests++; if (cyc != 4) begin n_fail++; $display("FAIL basic_cycles: got %0d want 4", cyc); end
    n_tests++; if (xg != 0) begin n_fail++; $display("FAIL basic_gnt_pulse: got %0d extra want 0", xg); end
    n_tests++; if (s !== 32'h8) begin n_fail++; $display("FAIL basic_sum: got %h want 00000008", s); end
    n_tests++; if (c !== 1'b0) begin n_fail++; $display("FAIL basic_cout: got %b want 0", c); end
    n_tests++; if (id !== 1'b0) begin n_fail++; $display("FAIL basic_id: got %b want 0", id); end
    accept(va, ba);
    n_tests++; if (va !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop: got %b want 0", va); end
    n_tests++; if (ba !== 1'b0) begin n_fail++; $display("FAIL basic_busy_drop: got %b want 0", ba); end
  endtask

  task automatic test_carry_inc;
    int gd, cyc, xg; bit ok; logic [31:0] s; logic c, id, va, ba;
    run_op(1'b1, 32'hFF, 32'h1, gd, cyc, xg, ok, s, c, id);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL inc_done: got %b want 1", ok); end
    n_tests++; if (gd != 1) begin n_fail++; $display("FAIL inc_gnt_delay: got %0d want 1", gd); end
    n_tests++; if (cyc != 5) begin n_fail++; $display("FAIL inc_cycles: got %0d want 5", cyc); end
    n_tests++; if (s !== 32'h100) begin n_fail++; $display("FAIL inc_sum: got %h want 00000100", s); end
    n_tests++; if (c !== 1'b0) begin n_fail++; $display("FAIL inc_cout: got %b want 0", c); end
    n_tests++; if (id !== 1'b1) begin n_fail++; $display("FAIL inc_id: got %b want 1", id); end
    accept(va, ba);
  endtask

  task automatic test_overflow;
    int gd, cyc, xg; bit ok; logic [31:0] s; logic c, id, va, ba;
    run_op(1'b0, 32'hFFFFFFFF, 32'h1, gd, cyc, xg, ok, s, c, id);
    n_tests++; if (cyc != 7) begin n_fail++; $display("FAIL ovf1_cycles: got %0d want 7", cyc); end
    n_tests++; if (s !== 32'h0) begin n_fail++; $display("FAIL ovf1_sum: got %h want 00000000", s); end
    n_tests++; if (c !== 1'b1) begin n_fail++; $display("FAIL ovf1_cout: got %b want 1", c); end
    accept(va, ba);
    run_op(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, gd, cyc, xg, ok, s, c, id);
    n_tests++; if (cyc != 7) begin n_fail++; $display("FAIL ovf2_cycles: got %0d want 7", cyc); end
    n_tests++; if (s !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL ovf2_sum: got %h want fffffffe", s); end
    n_tests++; if (c !== 1'b1) begin n_fail++; $display("FAIL ovf2_cout: got %b want 1", c); end
    n_tests++; if (id !== 1'b1) begin n_fail++; $display("FAIL ovf2_id: got %b want 1", id); end
    accept(va, ba);
  endtask

  task automatic test_backpressure;
    int gd, cyc, xg, w; bit ok; logic [31:0] s; logic c, id, va, ba;
    run_op(1'b0, 32'h10, 32'h20, gd, cyc, xg, ok, s, c, id);
    a1 = 32'h7; b1 = 32'h8; req1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_tests++;
      if (res_valid !== 1'b1 || res_sum !== 32'h30 || res_id !== 1'b0 || res_cout !== 1'b0 || gnt1 !== 1'b0)
        begin n_fail++; $display("FAIL bp_hold%0d: got v=%b sum=%h id=%b c=%b gnt1=%b want v=1 sum=00000030 id=0 c=0 gnt1=0",
                                 k, res_valid, res_sum, res_id, res_cout, gnt1); end
    end
    accept(va, ba);
    n_tests++; if (va !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop: got %b want 0", va); end
    n_tests++; if (gnt1 !== 1'b0) begin n_fail++; $display("FAIL bp_gnt_early: got %b want 0", gnt1); end
    @(negedge clk);
    n_tests++; if (gnt1 !== 1'b1) begin n_fail++; $display("FAIL bp_next_gnt: got %b want 1", gnt1); end
    req1 = 1'b0;
    w = 0;
    while (!res_valid && w < 40) begin @(negedge clk); w++; end
    n_tests++; if (res_sum !== 32'hF || res_id !== 1'b1)
      begin n_fail++; $display("FAIL bp_second: got sum=%h id=%b want sum=0000000f id=1", res_sum, res_id); end
    accept(va, ba);
  endtask

  task automatic test_round_robin;
    logic [31:0] exp_sum [3] = '{32'h2, 32'h4, 32'h2};
    logic        exp_id  [3] = '{1'b0, 1'b1, 1'b0};
    int n_done = 0, gcount = 0, cyc = 0;
    logic last_id = 1'b0;
    rst_n = 1'b0;
    a0 = 32'h1; b0 = 32'h1; a1 = 32'h2; b1 = 32'h2;
    req0 = 1'b1; req1 = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    while (n_done < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (res_ready) begin
        res_ready = 1'b0;
        if (last_id) req1 = 1'b1; else req0 = 1'b1;
        n_done++;
      end
      if (gnt0) begin gcount++; req0 = 1'b0; end
      if (gnt1) begin gcount++; req1 = 1'b0; end
      if (res_valid && n_done < 3) begin
        n_tests++;
        if (res_id !== exp_id[n_done] || res_sum !== exp_sum[n_done])
          begin n_fail++; $display("FAIL rr_service%0d: got id=%b sum=%h want id=%b sum=%h",
                                   n_done, res_id, res_sum, exp_id[n_done], exp_sum[n_done]); end
        last_id = res_id;
        res_ready = 1'b1;
      end
    end
    n_tests++; if (n_done != 3) begin n_fail++; $display("FAIL rr_complete: got %0d services want 3", n_done); end
    n_tests++; if (gcount != 3) begin n_fail++; $display("FAIL rr_gnt_count: got %0d want 3", gcount); end
    req0 = 1'b0; req1 = 1'b0; res_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_midop;
    int gd, cyc, xg, w; bit ok; logic [31:0] s; logic c, id, va, ba; logic g;
    a1 = 32'h00FFFF05; b1 = 32'h000001FE; req1 = 1'b1;
    w = 0;
    do begin @(negedge clk); w++; end while (!gnt1 && w < 20);
    req1 = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++; if (busy !== 1'b1 || res_sum !== 32'h00000103 || res_cout !== 1'b1)
      begin n_fail++; $display("FAIL mid_pre: got busy=%b sum=%h c=%b want busy=1 sum=00000103 c=1", busy, res_sum, res_cout); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (busy !== 1'b0 || res_valid !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0)
      begin n_fail++; $display("FAIL mid_ctrl: got busy=%b v=%b g0=%b g1=%b want all 0", busy, res_valid, gnt0, gnt1); end
    n_tests++; if (res_sum !== 32'h0 || res_id !== 1'b0 || res_cout !== 1'b0)
      begin n_fail++; $display("FAIL mid_data: got sum=%h id=%b c=%b want 0", res_sum, res_id, res_cout); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    g = 1'b0;
    repeat (2) begin @(negedge clk); g = g | gnt0 | gnt1; end
    n_tests++; if (g !== 1'b0 || busy !== 1'b0)
      begin n_fail++; $display("FAIL mid_idle: got gnt=%b busy=%b want 0 0", g, busy); end
    run_op(1'b1, 32'h12345678, 32'h11111111, gd, cyc, xg, ok, s, c, id);
    n_tests++; if (gd != 1) begin n_fail++; $display("FAIL mid_fresh_gnt: got %0d want 1", gd); end
    n_tests++; if (cyc != 4) begin n_fail++; $display("FAIL mid_fresh_cycles: got %0d want 4", cyc); end
    n_tests++; if (s !== 32'h23456789 || c !== 1'b0 || id !== 1'b1)
      begin n_fail++; $display("FAIL mid_fresh_result: got sum=%h c=%b id=%b want 23456789 0 1", s, c, id); end
    accept(va, ba);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_carry_inc;
    test_overflow;
    test_backpressure;
    test_round_robin;
    test_reset_midop;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
